// File: rtl/spider_cmd_sequencer.sv
// spider_cmd_sequencer
// Turns a stream of 16-bit command packets into neuron bus cycles.
// Packet kinds: register writes, cache loads through the router, run/wait, and read-back.
// Bus writes always take one dedicated WR_BUS cycle, so WE is a single-cycle pulse.
// The command stream is stalled during that cycle.
module spider_cmd_sequencer #(
    parameter logic [15:0] ROUTER_ADDR    = 16'h8003,
    parameter int          READ_LATENCY   = 1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        WE,
    output logic [15:0] Address,
    output logic [15:0] DataWrite,
    output logic        StartOperation,
    input  logic        ReadyNextOperation,
    input  logic [15:0] DataRead,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        REG_ADDR,
        REG_DATA,
        WR_BUS,
        LD_SEL,
        LD_BASE,
        LD_DATA,
        RUN_PULSE,
        RUN_HOLD,
        RUN_WAIT,
        RD_SEL,
        RD_BASE,
        RD_ISSUE,
        RD_WAIT,
        RD_OUT
    } stateT;

    localparam logic [3:0] OP_REG_WRITE  = 4'd1;
    localparam logic [3:0] OP_CACHE_LOAD = 4'd2;
    localparam logic [3:0] OP_RUN        = 4'd3;
    localparam logic [3:0] OP_READ       = 4'd4;

    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LAT_LAST  = 32'(READ_LATENCY);

    stateT       state;
    logic [3:0]  opcode;        // opcode of the packet in flight
    logic [11:0] remaining;     // data words / pairs / reads still to go
    logic [15:0] regAddr;       // address half of a REG_WRITE pair
    logic [15:0] nextAddr;      // next base+k address for loads and reads
    logic        routerPhase;   // the current WR_BUS cycle is the router select write
    logic [31:0] waitCount;     // cycles spent in RUN_WAIT
    logic [31:0] latencyCount;  // cycles since the read address was issued
    logic        readyArm;      // keeps cmd_ready low until the first edge after reset
    logic        acceptState;
    logic        cmdFire;

    // States in which a command word may be consumed
    always_comb begin
        acceptState = 1'b0;
        case (state)
            IDLE, REG_ADDR, REG_DATA, LD_SEL, LD_BASE, LD_DATA, RD_SEL, RD_BASE:
                acceptState = 1'b1;
            default:
                acceptState = 1'b0;
        endcase
    end

    assign cmd_ready = readyArm & acceptState;
    assign cmdFire   = cmd_valid & cmd_ready;
    assign busy      = (state != IDLE);

    // Packet FSM with all bus and result outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            opcode         <= 4'd0;
            remaining      <= 12'd0;
            regAddr        <= 16'd0;
            nextAddr       <= 16'd0;
            routerPhase    <= 1'b0;
            waitCount      <= 32'd0;
            latencyCount   <= 32'd0;
            readyArm       <= 1'b0;
            WE             <= 1'b0;
            Address        <= 16'd0;
            DataWrite      <= 16'd0;
            StartOperation <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= 16'd0;
            err            <= 1'b0;
        end else begin
            readyArm       <= 1'b1;
            WE             <= 1'b0;
            StartOperation <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmdFire) begin
                        opcode    <= cmd_data[15:12];
                        remaining <= cmd_data[11:0];
                        case (cmd_data[15:12])
                            OP_REG_WRITE:
                                state <= (cmd_data[11:0] == 12'd0) ? IDLE : REG_ADDR;
                            OP_CACHE_LOAD:
                                state <= LD_SEL;
                            OP_RUN: begin
                                StartOperation <= 1'b1;
                                state          <= RUN_PULSE;
                            end
                            OP_READ:
                                state <= RD_SEL;
                            default:
                                err <= 1'b1;
                        endcase
                    end
                end
                REG_ADDR: begin
                    if (cmdFire) begin
                        regAddr <= cmd_data;
                        state   <= REG_DATA;
                    end
                end
                REG_DATA: begin
                    if (cmdFire) begin
                        WE          <= 1'b1;
                        Address     <= regAddr;
                        DataWrite   <= cmd_data;
                        remaining   <= remaining - 12'd1;
                        routerPhase <= 1'b0;
                        state       <= WR_BUS;
                    end
                end
                WR_BUS: begin
                    if (routerPhase) begin
                        state <= (opcode == OP_READ) ? RD_BASE : LD_BASE;
                    end else if (remaining == 12'd0) begin
                        state <= IDLE;
                    end else begin
                        state <= (opcode == OP_REG_WRITE) ? REG_ADDR : LD_DATA;
                    end
                end
                LD_SEL, RD_SEL: begin
                    // The router select is written before the base word is taken
                    if (cmdFire) begin
                        WE          <= 1'b1;
                        Address     <= ROUTER_ADDR;
                        DataWrite   <= cmd_data;
                        routerPhase <= 1'b1;
                        state       <= WR_BUS;
                    end
                end
                LD_BASE: begin
                    if (cmdFire) begin
                        nextAddr <= cmd_data;
                        state    <= (remaining == 12'd0) ? IDLE : LD_DATA;
                    end
                end
                LD_DATA: begin
                    if (cmdFire) begin
                        WE          <= 1'b1;
                        Address     <= nextAddr;
                        DataWrite   <= cmd_data;
                        nextAddr    <= nextAddr + 16'd1;
                        remaining   <= remaining - 12'd1;
                        routerPhase <= 1'b0;
                        state       <= WR_BUS;
                    end
                end
                RUN_PULSE: begin
                    state <= RUN_HOLD;
                end
                RUN_HOLD: begin
                    // Ready may still show the previous operation here, so it is not looked at
                    waitCount <= 32'd0;
                    state     <= RUN_WAIT;
                end
                RUN_WAIT: begin
                    if (ReadyNextOperation) begin
                        state <= IDLE;
                    end else if (waitCount >= WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        waitCount <= waitCount + 32'd1;
                    end
                end
                RD_BASE: begin
                    if (cmdFire) begin
                        Address  <= cmd_data;
                        nextAddr <= cmd_data + 16'd1;
                        state    <= (remaining == 12'd0) ? IDLE : RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    // Address is already on the bus with WE low; count the latency from here
                    if (READ_LATENCY == 0) begin
                        res_data  <= DataRead;
                        res_valid <= 1'b1;
                        state     <= RD_OUT;
                    end else begin
                        latencyCount <= 32'd1;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (latencyCount >= LAT_LAST) begin
                        res_data  <= DataRead;
                        res_valid <= 1'b1;
                        state     <= RD_OUT;
                    end else begin
                        latencyCount <= latencyCount + 32'd1;
                    end
                end
                RD_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        remaining <= remaining - 12'd1;
                        if (remaining == 12'd1) begin
                            state <= IDLE;
                        end else begin
                            Address  <= nextAddr;
                            nextAddr <= nextAddr + 16'd1;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spider_cmd_sequencer.sv
// Testbench for spider_cmd_sequencer.
// A neuron model provides DataRead from a memory with one cycle of latency.
// A monitor collects every bus write.
// Each test task builds its expected writes and reads directly from the packet contents.
module tb_spider_cmd_sequencer;

    localparam logic [15:0] ROUTER = 16'h8003;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        WE;
    logic [15:0] Address;
    logic [15:0] DataWrite;
    logic        StartOperation;
    logic        ReadyNextOperation;
    logic [15:0] DataRead;
    logic        busy;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] wrQ[$];          // observed writes {Address, DataWrite}
    int          weLong   = 0;    // WE seen high on consecutive cycles
    int          weReady  = 0;    // WE high while cmd_ready high
    int          weStart  = 0;    // WE and StartOperation high together
    int          startCnt = 0;    // cycles with StartOperation high
    logic        wePrev   = 1'b0;
    logic [15:0] readMem [0:65535];

    spider_cmd_sequencer #(
        .ROUTER_ADDR   (ROUTER),
        .READ_LATENCY  (1),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .WE                (WE),
        .Address           (Address),
        .DataWrite         (DataWrite),
        .StartOperation    (StartOperation),
        .ReadyNextOperation(ReadyNextOperation),
        .DataRead          (DataRead),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    // Neuron read port: data for the address seen at one edge is valid during the next cycle
    always @(posedge clk) DataRead <= readMem[Address];

    // Bus monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (WE) begin
                wrQ.push_back({Address, DataWrite});
                if (cmd_ready) weReady <= weReady + 1;
                if (StartOperation) weStart <= weStart + 1;
                if (wePrev) weLong <= weLong + 1;
            end
            if (StartOperation) startCnt <= startCnt + 1;
            wePrev <= WE;
        end else begin
            wePrev <= 1'b0;
        end
    end

    // Offer one command word; called and returning at a falling edge
    task automatic sendWord(input logic [15:0] w);
        int t;
        t = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL cmd_accept: word %h cmd_ready=%b required 1", w, cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input string name);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_idle: busy=%b required 0", name, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulseReset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wrQ.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = 16'd0;
        res_ready = 1'b0;
        ReadyNextOperation = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({WE, Address, DataWrite, StartOperation, res_valid, res_data, err, busy, cmd_ready} !== 53'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: WE=%b Addr=%h DW=%h Start=%b rv=%b rd=%h err=%b busy=%b rdy=%b required all 0",
                     WE, Address, DataWrite, StartOperation, res_valid, res_data, err, busy, cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready_rise: cmd_ready=%b required 1", cmd_ready);
        end
        $display("reset: released, cmd_ready=%b", cmd_ready);
    endtask

    task automatic test_reg_write;
        logic [15:0] w[7];
        logic [31:0] expW[$];
        w = '{16'h1003, 16'h8000, 16'h0000, 16'h8001, 16'h0000, 16'h8002, 16'h0002};
        expW = '{{16'h8000, 16'h0000}, {16'h8001, 16'h0000}, {16'h8002, 16'h0002}};
        wrQ.delete();
        foreach (w[i]) sendWord(w[i]);
        waitIdle("reg_write");
        compared++;
        if (wrQ.size() != expW.size()) begin
            mismatched++;
            $display("FAIL reg_write_count: got %0d writes required %0d", wrQ.size(), expW.size());
        end
        foreach (expW[i]) begin
            if (i < wrQ.size()) begin
                compared++;
                if (wrQ[i] !== expW[i]) begin
                    mismatched++;
                    $display("FAIL reg_write_%0d: got %h required %h", i, wrQ[i], expW[i]);
                end
            end
        end
        $display("reg_write: %0d writes observed", wrQ.size());
    endtask

    task automatic test_cache_load;
        logic [15:0] w[5];
        logic [31:0] expW[$];
        w = '{16'h2002, 16'h0001, 16'h0000, 16'h0000, 16'h0001};
        expW = '{{ROUTER, 16'h0001}, {16'h0000, 16'h0000}, {16'h0001, 16'h0001}};
        wrQ.delete();
        foreach (w[i]) sendWord(w[i]);
        waitIdle("cache_load");
        compared++;
        if (wrQ.size() != expW.size()) begin
            mismatched++;
            $display("FAIL cache_load_count: got %0d writes required %0d", wrQ.size(), expW.size());
        end
        foreach (expW[i]) begin
            if (i < wrQ.size()) begin
                compared++;
                if (wrQ[i] !== expW[i]) begin
                    mismatched++;
                    $display("FAIL cache_load_%0d: got %h required %h", i, wrQ[i], expW[i]);
                end
            end
        end
        compared++;
        if (weReady != 0) begin
            mismatched++;
            $display("FAIL cache_load_ready_in_bus: %0d cycles with WE and cmd_ready required 0", weReady);
        end
        $display("cache_load: %0d writes observed", wrQ.size());
    endtask

    task automatic test_read;
        logic [15:0] w[3];
        logic [15:0] expR[2];
        logic [15:0] cap;
        int t;
        readMem[0] = 16'h3C00;
        readMem[1] = 16'h4000;
        w = '{16'h4002, 16'h0004, 16'h0000};
        expR = '{16'h3C00, 16'h4000};
        wrQ.delete();
        foreach (w[i]) sendWord(w[i]);
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (res_valid !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            compared++;
            if (res_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL read_valid_%0d: res_valid=%b required 1", k, res_valid);
                break;
            end
            cap = res_data;
            repeat (5) begin
                @(negedge clk);
                compared++;
                if (res_valid !== 1'b1 || res_data !== cap) begin
                    mismatched++;
                    $display("FAIL read_stall_%0d: rv=%b data=%h required 1 and %h", k, res_valid, res_data, cap);
                end
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            compared++;
            if (cap !== expR[k]) begin
                mismatched++;
                $display("FAIL read_data_%0d: got %h required %h", k, cap, expR[k]);
            end
            @(negedge clk);
            compared++;
            if (res_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL read_release_%0d: res_valid=%b required 0", k, res_valid);
            end
            $display("read: word %0d = %h", k, cap);
        end
        waitIdle("read");
        compared++;
        if (wrQ.size() != 1 || wrQ[0] !== {ROUTER, 16'h0004}) begin
            mismatched++;
            $display("FAIL read_router_write: got %0d writes first %h required 1 write %h",
                     wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 32'd0, {ROUTER, 16'h0004});
        end
    endtask

    task automatic test_run;
        int s0;
        int w0;
        int drops;
        int t;
        s0 = startCnt;
        w0 = wrQ.size();
        drops = 0;
        ReadyNextOperation = 1'b0;
        sendWord(16'h3000);
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b1) drops++;
        end
        compared++;
        if (drops != 0) begin
            mismatched++;
            $display("FAIL run_busy: busy low in %0d of 20 waiting cycles required 0", drops);
        end
        ReadyNextOperation = 1'b1;
        t = 0;
        while (busy !== 1'b0 && t < 5) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL run_done: busy=%b required 0", busy);
        end
        @(negedge clk);
        compared++;
        if (startCnt - s0 != 1) begin
            mismatched++;
            $display("FAIL run_start: %0d start cycles required 1", startCnt - s0);
        end
        compared++;
        if (wrQ.size() != w0 || weStart != 0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL run_side: writes=%0d overlap=%0d err=%b required %0d 0 0", wrQ.size(), weStart, err, w0);
        end
        $display("run: start pulses=%0d done after %0d cycles", startCnt - s0, 20 + t);
    endtask

    task automatic test_random;
        logic [15:0] words[$];
        logic [31:0] expW[$];
        logic [15:0] expR[$];
        logic [15:0] sel, base, a, d, cap;
        int op, n, t, s0;
        s0 = weLong;
        for (int p = 0; p < 12; p++) begin
            words.delete();
            expW.delete();
            expR.delete();
            op = $urandom_range(0, 2);
            n  = $urandom_range(0, 4);
            sel  = 16'($urandom);
            base = 16'($urandom);
            case (op)
                0: begin
                    words.push_back(16'h1000 | 16'(n));
                    for (int i = 0; i < n; i++) begin
                        a = 16'($urandom);
                        d = 16'($urandom);
                        words.push_back(a);
                        words.push_back(d);
                        expW.push_back({a, d});
                    end
                end
                1: begin
                    words.push_back(16'h2000 | 16'(n));
                    words.push_back(sel);
                    words.push_back(base);
                    expW.push_back({ROUTER, sel});
                    for (int k = 0; k < n; k++) begin
                        d = 16'($urandom);
                        words.push_back(d);
                        expW.push_back({base + 16'(k), d});
                    end
                end
                default: begin
                    words.push_back(16'h4000 | 16'(n));
                    words.push_back(sel);
                    words.push_back(base);
                    expW.push_back({ROUTER, sel});
                    for (int k = 0; k < n; k++) expR.push_back(readMem[base + 16'(k)]);
                end
            endcase
            wrQ.delete();
            foreach (words[i]) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sendWord(words[i]);
            end
            foreach (expR[k]) begin
                t = 0;
                while (res_valid !== 1'b1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                compared++;
                if (res_valid !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rand_read_valid p%0d k%0d: res_valid=%b required 1", p, k, res_valid);
                    break;
                end
                cap = res_data;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                res_ready = 1'b1;
                @(posedge clk);
                #1;
                res_ready = 1'b0;
                compared++;
                if (cap !== expR[k]) begin
                    mismatched++;
                    $display("FAIL rand_read_data p%0d k%0d: got %h required %h", p, k, cap, expR[k]);
                end
                @(negedge clk);
            end
            waitIdle("random");
            compared++;
            if (wrQ.size() != expW.size()) begin
                mismatched++;
                $display("FAIL rand_write_count p%0d: got %0d required %0d", p, wrQ.size(), expW.size());
            end
            foreach (expW[i]) begin
                if (i < wrQ.size()) begin
                    compared++;
                    if (wrQ[i] !== expW[i]) begin
                        mismatched++;
                        $display("FAIL rand_write p%0d #%0d: got %h required %h", p, i, wrQ[i], expW[i]);
                    end
                end
            end
            $display("random: packet %0d op=%0d n=%0d writes=%0d reads=%0d", p, op, n, wrQ.size(), expR.size());
        end
        compared++;
        if (weLong != s0) begin
            mismatched++;
            $display("FAIL we_width: %0d multi-cycle WE pulses required 0", weLong - s0);
        end
    endtask

    task automatic test_run_timeout;
        int t;
        ReadyNextOperation = 1'b0;
        sendWord(16'h3000);
        t = 0;
        while (busy !== 1'b0 && t < 1100) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_err: busy=%b err=%b required 0 1", busy, err);
        end
        compared++;
        if (t < 1024 || t > 1028) begin
            mismatched++;
            $display("FAIL timeout_len: idle after %0d cycles required 1024..1028", t);
        end
        ReadyNextOperation = 1'b1;
        $display("run_timeout: idle after %0d cycles err=%b", t, err);
    endtask

    task automatic test_bad_opcode;
        int s0;
        pulseReset();
        s0 = startCnt;
        sendWord(16'h7000);
        compared++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL bad_op_err: err=%b busy=%b required 1 0", err, busy);
        end
        sendWord(16'h3000);
        waitIdle("bad_op_run");
        compared++;
        if (startCnt - s0 != 1 || wrQ.size() != 0) begin
            mismatched++;
            $display("FAIL bad_op_run: starts=%0d writes=%0d required 1 0", startCnt - s0, wrQ.size());
        end
        $display("bad_opcode: err=%b starts=%0d", err, startCnt - s0);
    endtask

    task automatic test_reset_mid_load;
        pulseReset();
        sendWord(16'h2003);
        sendWord(16'h0005);
        sendWord(16'h0100);
        sendWord(16'hAAAA);
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_load_state: busy=%b cmd_ready=%b required 1 1", busy, cmd_ready);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({WE, Address, DataWrite, StartOperation, res_valid, res_data, err, busy, cmd_ready} !== 53'd0) begin
            mismatched++;
            $display("FAIL mid_load_reset: WE=%b Addr=%h DW=%h Start=%b rv=%b rd=%h err=%b busy=%b rdy=%b required all 0",
                     WE, Address, DataWrite, StartOperation, res_valid, res_data, err, busy, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wrQ.delete();
        sendWord(16'h1001);
        sendWord(16'h1234);
        sendWord(16'hABCD);
        waitIdle("after_reset");
        compared++;
        if (wrQ.size() != 1 || wrQ[0] !== {16'h1234, 16'hABCD}) begin
            mismatched++;
            $display("FAIL after_reset_parse: writes=%0d first=%h required 1 %h",
                     wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 32'd0, {16'h1234, 16'hABCD});
        end
        $display("reset_mid_load: writes after reset=%0d", wrQ.size());
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) readMem[i] = 16'(i * 40503 + 4660);
        test_reset();
        test_reg_write();
        test_cache_load();
        test_read();
        test_run();
        test_random();
        test_run_timeout();
        test_bad_opcode();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
